// File: rtl/stage_tap_ctrl_pkg.sv
// Shared constants, FSM state type and memory control bundle for the stage tap controller.
package stage_tap_ctrl_pkg;

    localparam int STAGE_TAP_LANES = 6;
    localparam int STAGE_TAP_DEPTH = 4;
    localparam int STAGE_TAP_AW    = 2;
    localparam int STAGE_TAP_SW    = 3;

    localparam logic [STAGE_TAP_SW-1:0] NO_SUB = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWEEP = 3'd1,
        ST_DRAIN = 3'd2,
        ST_H_RD  = 3'd3,
        ST_H_WR  = 3'd4
    } tap_state_e;

    typedef struct packed {
        logic [STAGE_TAP_AW-1:0] addr;
        logic                    rd_en;
        logic                    wr_en;
        logic [STAGE_TAP_SW-1:0] sub_addr;
        logic [31:0]             sub_data;
    } tap_ctrl_t;

endpackage

// File: rtl/stage_tap_sweep_gen.sv
// Sweep address counter plus the one-cycle valid/addr/last delay that lines up with read data.
module stage_tap_sweep_gen
    import stage_tap_ctrl_pkg::*;
#(
    parameter int DEPTH = STAGE_TAP_DEPTH,
    parameter int AW    = STAGE_TAP_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_run,
    output logic [AW-1:0] o_addr,
    output logic          o_at_end,
    output logic          o_vld,
    output logic [AW-1:0] o_vld_addr,
    output logic          o_last
);

    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_vld_addr;
    logic          r_vld;
    logic          r_last;

    assign o_at_end   = (r_cnt == AW'(DEPTH - 1));
    assign o_addr     = r_cnt;
    assign o_vld      = r_vld;
    assign o_vld_addr = r_vld_addr;
    assign o_last     = r_last;

    // Counter returns to 0 whenever the sweep is not running, so it never wraps into a second pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_vld      <= 1'b0;
            r_vld_addr <= '0;
            r_last     <= 1'b0;
        end else begin
            r_cnt      <= (i_run && !o_at_end) ? r_cnt + 1'b1 : '0;
            r_vld      <= i_run;
            r_vld_addr <= r_cnt;
            r_last     <= i_run && o_at_end;
        end
    end

endmodule

// File: rtl/stage_tap_ctrl.sv
// Arbitrates the stage tap memory between compute sweep, update writeback and host lane RMW.
// Optional statistics counters are built when STAGE_TAP_CTRL_STATS_EN is defined.
module stage_tap_ctrl
    import stage_tap_ctrl_pkg::*;
#(
    parameter int LANES = STAGE_TAP_LANES,
    parameter int DEPTH = STAGE_TAP_DEPTH,
    parameter int AW    = STAGE_TAP_AW,
    parameter int SW    = STAGE_TAP_SW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sweep_start,
    output logic                  sweep_busy,
    output logic                  sweep_valid,
    output logic [AW-1:0]         sweep_addr,
    output logic [32*LANES-1:0]   sweep_data,
    output logic                  sweep_last,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [AW-1:0]         upd_addr,
    input  logic [32*LANES-1:0]   upd_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [AW-1:0]         host_addr,
    input  logic [SW-1:0]         host_lane,
    input  logic [31:0]           host_data,
    output logic                  host_err,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [SW-1:0]         mem_sub_addr,
    output logic [31:0]           mem_sub_data,
    output logic [32*LANES-1:0]   mem_wr_data,
    input  logic [32*LANES-1:0]   mem_rd_data
`ifdef STAGE_TAP_CTRL_STATS_EN
    ,
    output logic [15:0]           host_stall_cnt,
    output logic [15:0]           sweep_cnt
`endif
);

    localparam logic [SW-1:0] LANE_LIM = SW'(LANES);

    tap_state_e          r_state, w_state_nxt;
    logic                r_pend;
    logic [AW-1:0]       r_h_addr;
    logic [SW-1:0]       r_h_lane;
    logic [31:0]         r_h_data;

    tap_ctrl_t           w_ctrl;
    logic [32*LANES-1:0] w_wr_data;
    logic                w_sweep_req;
    logic                w_pend_clr;
    logic                w_host_acc;
    logic                w_run;
    logic [AW-1:0]       w_cnt;
    logic                w_at_end;
    logic                w_vld;
    logic [AW-1:0]       w_vld_addr;
    logic                w_last;

    assign w_sweep_req = r_pend | sweep_start;
    assign w_run       = (r_state == ST_SWEEP);

    stage_tap_sweep_gen #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sweep_gen (
        .clk        (clk),
        .reset      (reset),
        .i_run      (w_run),
        .o_addr     (w_cnt),
        .o_at_end   (w_at_end),
        .o_vld      (w_vld),
        .o_vld_addr (w_vld_addr),
        .o_last     (w_last)
    );

    // Grants and memory strobes are suppressed while reset is held so no access leaks out.
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = '{addr: '0, rd_en: 1'b0, wr_en: 1'b0, sub_addr: NO_SUB, sub_data: '0};
        w_wr_data   = '0;
        upd_ready   = 1'b0;
        host_ready  = 1'b0;
        host_err    = 1'b0;
        w_host_acc  = 1'b0;
        w_pend_clr  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sweep_req) begin
                        w_state_nxt = ST_SWEEP;
                        w_pend_clr  = 1'b1;
                    end else if (upd_valid) begin
                        upd_ready    = 1'b1;
                        w_ctrl.wr_en = 1'b1;
                        w_ctrl.addr  = upd_addr;
                        w_wr_data    = upd_data;
                    end else if (host_valid) begin
                        host_ready = 1'b1;
                        if (host_lane >= LANE_LIM) begin
                            host_err = 1'b1;
                        end else begin
                            w_host_acc  = 1'b1;
                            w_state_nxt = ST_H_RD;
                        end
                    end
                end
                ST_SWEEP: begin
                    w_ctrl.rd_en = 1'b1;
                    w_ctrl.addr  = w_cnt;
                    if (w_at_end) w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: w_state_nxt = ST_IDLE;
                ST_H_RD: begin
                    w_ctrl.rd_en = 1'b1;
                    w_ctrl.addr  = r_h_addr;
                    w_state_nxt  = ST_H_WR;
                end
                ST_H_WR: begin
                    w_ctrl.wr_en    = 1'b1;
                    w_ctrl.addr     = r_h_addr;
                    w_ctrl.sub_addr = r_h_lane;
                    w_ctrl.sub_data = r_h_data;
                    w_wr_data       = mem_rd_data;
                    w_state_nxt     = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pend   <= 1'b0;
            r_h_addr <= '0;
            r_h_lane <= '0;
            r_h_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pend_clr)
                r_pend <= 1'b0;
            else if (sweep_start)
                r_pend <= 1'b1;
            if (w_host_acc) begin
                r_h_addr <= host_addr;
                r_h_lane <= host_lane;
                r_h_data <= host_data;
            end
        end
    end

    assign mem_addr     = w_ctrl.addr;
    assign mem_rd_en    = w_ctrl.rd_en;
    assign mem_wr_en    = w_ctrl.wr_en;
    assign mem_sub_addr = w_ctrl.sub_addr;
    assign mem_sub_data = w_ctrl.sub_data;
    assign mem_wr_data  = w_wr_data;

    assign sweep_busy  = (r_state == ST_SWEEP) || (r_state == ST_DRAIN);
    assign sweep_valid = w_vld;
    assign sweep_addr  = w_vld_addr;
    assign sweep_last  = w_last;
    assign sweep_data  = w_vld ? mem_rd_data : '0;

`ifdef STAGE_TAP_CTRL_STATS_EN
    logic [15:0] r_host_stall_cnt;
    logic [15:0] r_sweep_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_stall_cnt <= '0;
            r_sweep_cnt      <= '0;
        end else begin
            if (host_valid && !host_ready && r_host_stall_cnt != 16'hFFFF)
                r_host_stall_cnt <= r_host_stall_cnt + 16'd1;
            if (r_state == ST_DRAIN && r_sweep_cnt != 16'hFFFF)
                r_sweep_cnt <= r_sweep_cnt + 16'd1;
        end
    end

    assign host_stall_cnt = r_host_stall_cnt;
    assign sweep_cnt      = r_sweep_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/stage_tap_ctrl.md
Name: stage_tap_ctrl

Overview:
- Sequences and arbitrates the stage tap memory: 6 lanes x 32 bit, DEPTH words, 1-cycle registered read.
- Three requesters share the memory:
  - compute sweep: streams all words in order to the MAC stage.
  - update writeback: full-width tap writes after training.
  - host loader: single 32-bit lane writes, done as read-modify-write (RMW).
- Sits between the stage datapath/host bus and the tap memory bank; drives the memory's address, enables, sub-lane select/data and write data.

Parameters:
- LANES, 6, number of 32-bit lanes per word
- DEPTH, 4, words in tap memory
- AW, 2, address width (clog2 DEPTH)
- SW, 3, sub-lane select width; value 7 (all ones) = no lane substitution

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sweep_start  in  1  pulse; request a full read sweep
- sweep_busy  out  1  sweep accepted and not yet finished
- sweep_valid  out  1  sweep_data valid
- sweep_addr  out  AW  word index of sweep_data
- sweep_data  out  32*LANES  tap word
- sweep_last  out  1  with final sweep_valid
- upd_valid  in  1  update writeback request
- upd_ready  out  1  update accepted this cycle
- upd_addr  in  AW  update word address
- upd_data  in  32*LANES  update word
- host_valid  in  1  host lane write request
- host_ready  out  1  host request accepted (RMW started)
- host_addr  in  AW  word address
- host_lane  in  SW  lane 0..LANES-1
- host_data  in  32  lane data
- host_err  out  1  1-cycle pulse; host_lane >= LANES, request dropped
- mem_addr  out  AW  memory address
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_sub_addr  out  SW  lane to take from mem_sub_data
- mem_sub_data  out  32  substituted lane data
- mem_wr_data  out  32*LANES  full write word
- mem_rd_data  in  32*LANES  read data, valid 1 cycle after mem_rd_en

Behaviour:
- Reset values:
  - All outputs 0, except mem_sub_addr = 7.
  - FSM = IDLE; pending-sweep flag cleared.
  - Reset mid-operation abandons any sweep or RMW; no write is issued.
- FSM states: IDLE, SWEEP, DRAIN, H_RD, H_WR.
- IDLE arbitration, fixed priority: pending sweep > upd_valid > host_valid.
- sweep_start while busy sets a pending flag; repeated starts merge into one.
- Sweep:
  - IDLE->SWEEP: sweep_busy = 1; addr counter = 0.
  - SWEEP: mem_rd_en = 1 and mem_addr = counter each cycle; counter increments.
  - At counter == DEPTH-1 -> DRAIN.
  - DRAIN: 1 cycle to capture the last read -> IDLE.
  - sweep_valid/sweep_data/sweep_addr are registered copies of the read, 1 cycle after each mem_rd_en. That gives DEPTH valid beats back to back, with sweep_last on beat DEPTH-1.
  - sweep_busy falls in the cycle after sweep_last.
  - Total sweep: DEPTH+1 cycles from the IDLE grant.
- Update:
  - In IDLE with no sweep pending, upd_ready = upd_valid.
  - Same cycle: mem_wr_en = 1, mem_addr = upd_addr, mem_wr_data = upd_data, mem_sub_addr = 7.
  - FSM stays in IDLE.
- Host write:
  - Host granted only if no sweep is pending and upd_valid = 0; host_ready is a 1-cycle pulse on grant.
  - host_lane >= LANES: host_ready and host_err pulse together, no memory access.
  - Otherwise latch addr/lane/data and go H_RD.
  - H_RD: mem_rd_en = 1 at the latched address -> H_WR.
  - H_WR: mem_wr_en = 1, mem_wr_data = mem_rd_data, mem_sub_addr = lane, mem_sub_data = data -> IDLE.
  - Total 3 cycles. Updates and sweeps wait; an RMW is never split.
- Simultaneous events:
  - sweep_start together with upd_valid in IDLE: sweep wins; upd stalls (upd_ready = 0).
  - sweep_start during an RMW: pends, granted on return to IDLE.
- Outside write cycles, mem_sub_addr = 7 and mem_wr_en = 0.
- Address counter wraps at DEPTH-1 only by FSM exit; no wrap writes.

Optional Feature:
- Macro: STAGE_TAP_CTRL_STATS_EN.
- With it:
  - Adds outputs host_stall_cnt[15:0] (cycles host_valid=1 && host_ready=0) and sweep_cnt[15:0] (completed sweeps).
  - Both counters saturate at 16'hFFFF; reset to 0.
- Without it: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - STAGE_TAP_LANES, STAGE_TAP_DEPTH and the NO_SUB constant (7).
  - FSM state enum typedef.
  - A packed struct tap ctrl typedef (addr, rd_en, wr_en, sub_addr, sub_data) matching the memory's control bundle, so top level can pack the mem_* outputs.
- One natural sub-module: stage_tap_sweep_gen (address counter + rd-valid/last delay pipeline).

Test Plan:
- Sweep after preload (word k lane j = 0x100*k+j), pulse sweep_start -> sweep_valid on cycles 2..5, sweep_addr 0..3, sweep_data matches, sweep_last on addr 3, sweep_busy low cycle 6.
- Host write addr 2 lane 4 data 0xDEADBEEF -> read at cycle 1, write at cycle 2; later sweep shows word 2 lane 4 = 0xDEADBEEF, other lanes unchanged.
- sweep_start + upd_valid(addr 1) + host_valid same cycle -> sweep first; upd_ready one cycle after DRAIN; host RMW after that.
- host_lane = 6 -> host_ready and host_err pulse, no mem_wr_en, memory unchanged.
- Reset asserted in H_RD -> no mem_wr_en that or following cycle; outputs at reset values; memory word unchanged.
- With STATS_EN: host held valid during a 5-cycle sweep -> host_stall_cnt = 5, sweep_cnt = 1.
